stdout_uart_tx: RTL and testbench

Serial sink for the processor's `stdout`/`stdout_en` byte stream: every cycle `stdout_en` is high, the byte on `stdout` is buffered in a small FIFO and later shifted out as an 8N1 UART frame on `tx`. The block sits between the core and the board pin, decoupling the core's burst output from the slow serial line.

---
 rtl/stdout_uart_pkg.sv | 16 +
 rtl/stdout_uart_tx_byte_fifo.sv | 62 ++++++
 rtl/stdout_uart_tx.sv | 135 +++++++++++++
 tb/tb_stdout_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stdout_uart_pkg.sv
// Shared definitions for the stdout UART transmitter: FSM encoding and line constants.
package stdout_uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_IDX_W      = $clog2(UART_DATA_BITS);
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic UART_START_LEVEL = ~UART_IDLE_LEVEL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/stdout_uart_tx_byte_fifo.sv
// Single-clock byte FIFO; AW-bit pointers wrap naturally, occupancy kept separately at AW+1 bits.
module byte_fifo
    import stdout_uart_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic [AW:0]               count,
    output logic                      full,
    output logic                      empty
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q;
    logic [AW-1:0]             rd_ptr_q;
    logic [AW:0]               count_q;
    logic                      do_push;
    logic                      do_pop;

    // Full/empty come from the pre-edge count, so a pop never frees room for a same-cycle push.
    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// Buffers the core's stdout byte stream and shifts each byte out as an 8N1 UART frame on tx.
module stdout_uart_tx
    import stdout_uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] stdout,
    input  logic                      stdout_en,
    output logic                      tx,
    output logic                      busy,
    output logic                      overflow,
    output logic [FIFO_AW:0]          fifo_count,
    output uart_state_e               state_dbg
);

    localparam int              BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [UART_IDX_W-1:0] LAST_BIT = UART_IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               state_q;
    logic [BW-1:0]             baud_q;
    logic [UART_IDX_W-1:0]     bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      tx_q;
    logic                      overflow_q;

    logic                      fifo_pop;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_end;

    // Handshake: stdout_en is a valid strobe with no ready; every offered byte is either
    // written on that edge or, when the FIFO is full, dropped and recorded in overflow.
    byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stdout_en),
        .din   (stdout),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end  = (baud_q == BAUD_LAST);
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (stdout_en && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    tx_q   <= UART_IDLE_LEVEL;
                    if (fifo_pop) begin
                        shift_q <= fifo_dout;
                        tx_q    <= UART_START_LEVEL;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == LAST_BIT) begin
                            tx_q    <= UART_IDLE_LEVEL;
                            state_q <= ST_STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + UART_IDX_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        // Next frame starts on the very edge this stop bit ends.
                        if (fifo_pop) begin
                            shift_q <= fifo_dout;
                            tx_q    <= UART_START_LEVEL;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx: per-cycle frame checks at CLK_DIV=4 plus a decoded run at CLK_DIV=2.
module tb_stdout_uart_tx;
  import stdout_uart_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [7:0] stdout_a, stdout_b;
  logic en_a, en_b;
  logic tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b;
  logic [2:0] cnt_a, cnt_b;
  uart_state_e st_a, st_b;

  stdout_uart_tx #(.CLK_DIV(4), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .stdout(stdout_a), .stdout_en(en_a),
    .tx(tx_a), .busy(busy_a), .overflow(ovf_a), .fifo_count(cnt_a), .state_dbg(st_a));

  stdout_uart_tx #(.CLK_DIV(2), .FIFO_AW(2)) dut_b (
    .clk(clk), .reset(reset), .stdout(stdout_b), .stdout_en(en_b),
    .tx(tx_b), .busy(busy_b), .overflow(ovf_b), .fifo_count(cnt_b), .state_dbg(st_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = line level during bit slot i (slot 0 = start)
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    stdout_a = d;
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Called just after the edge where the start bit fell; returns just after the frame's last edge.
  task automatic check_frame(input string name, input logic [9:0] frame);
    for (int k = 0; k < 40; k++) begin
      chk({name, "_tx"}, 32'(tx_a), 32'(frame[k / 4]));
      chk({name, "_busy"}, 32'(busy_a), 32'd1);
      tick();
    end
  endtask

  task automatic idle_watch_a(input string name, input int cycles, input logic exp_ovf);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || ovf_a !== exp_ovf || cnt_a !== 3'd0) bad++;
      tick();
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'h41, frame: 10'h282};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'hA5, frame: 10'h34A};
    vecs[4] = '{data: 8'h3C, frame: 10'h278};

    reset = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    stdout_a = 8'h00; stdout_b = 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'(ST_IDLE));
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    idle_watch_a("idle100", 100, 1'b0);

    // table: single byte, E0 push, E1 start, busy falls at E1+40
    for (int v = 0; v < 5; v++) begin
      push_a(vecs[v].data);
      chk("e0_cnt", 32'(cnt_a), 32'd1);
      chk("e0_tx", 32'(tx_a), 32'd1);
      tick();
      chk("e1_cnt", 32'(cnt_a), 32'd0);
      check_frame($sformatf("vec%0d", v), vecs[v].frame);
      chk("end_busy", 32'(busy_a), 32'd0);
      chk("end_tx", 32'(tx_a), 32'd1);
      chk("end_state", 32'(st_a), 32'(ST_IDLE));
      repeat (5) tick();
    end

    // 0x00 then 0xFF three cycles apart: zero-gap frames
    push_a(8'h00);
    fork
      begin
        tick(); tick();
        push_a(8'hFF);
      end
      begin
        tick();
        check_frame("b2b_00", frame_of(8'h00));
        check_frame("b2b_ff", frame_of(8'hFF));
      end
    join
    chk("b2b_busy", 32'(busy_a), 32'd0);
    idle_watch_a("b2b_idle", 10, 1'b0);

    // overflow: 0x10..0x15 every 3 cycles into depth 4
    push_a(8'h10);
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          tick(); tick();
          push_a(8'h10 + 8'(i));
          if (i < 5) chk("ovf_early", 32'(ovf_a), 32'd0);
        end
        chk("ovf_set", 32'(ovf_a), 32'd1);
        chk("ovf_cnt", 32'(cnt_a), 32'd4);
      end
      begin
        tick();
        for (int i = 0; i < 5; i++) check_frame($sformatf("ovf_f%0d", i), frame_of(8'h10 + 8'(i)));
      end
    join
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    idle_watch_a("ovf_no_0x15", 60, 1'b1);
    do_reset();
    chk("ovf_cleared", 32'(ovf_a), 32'd0);

    // reset at cycle 15 of an 0xA5 frame with two bytes queued
    push_a(8'hA5);
    push_a(8'h5A);
    chk("mid_start", 32'(tx_a), 32'd0);
    push_a(8'hC3);
    repeat (14) tick();
    chk("mid_cnt", 32'(cnt_a), 32'd2);
    chk("mid_tx", 32'(tx_a), 32'(frame_of(8'hA5)[15 / 4]));
    reset = 1'b1;
    tick();
    chk("mid_rst_tx", 32'(tx_a), 32'd1);
    chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;
    idle_watch_a("mid_no_frames", 60, 1'b0);
    push_a(8'h3C);
    tick();
    check_frame("post_rst", vecs[4].frame);
    chk("post_rst_busy", 32'(busy_a), 32'd0);

    // CLK_DIV=2: 16 bytes below line rate, decoded and scoreboarded
    begin
      int got;
      got = 0;
      fork
        begin
          for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            stdout_b = d;
            en_b = 1'b1;
            tick();
            en_b = 1'b0;
            repeat ($urandom_range(22, 30)) tick();
          end
        end
        begin
          int n;
          n = 0;
          while (got < 16 && n < 3000) begin
            if (tx_b === 1'b0) begin
              logic [7:0] rx;
              logic [7:0] exp;
              for (int k = 0; k < 8; k++) begin
                tick(); tick();
                rx[k] = tx_b;
              end
              tick(); tick();
              chk("rnd_stop", 32'(tx_b), 32'd1);
              exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
              chk($sformatf("rnd_byte%0d", got), 32'(rx), 32'(exp));
              got++;
              tick();
              n += 19;
            end else begin
              tick();
              n++;
            end
          end
        end
      join
      chk("rnd_count", 32'(got), 32'd16);
      chk("rnd_left", 32'(exp_q.size()), 32'd0);
      chk("rnd_ovf", 32'(ovf_b), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
